keypad_scan: RTL and testbench

Matrix keypad scanner for the 12-key (3 columns × 4 rows) keypad on the training board; the input-side counterpart to the time-multiplexed 7-segment output stage. Drives one keypad column at a time, samples the rows, debounces whole-keypad snapshots, and emits a one-cycle `key_valid` pulse with a 4-bit `key_code` per debounced press. Sits between the board keypad pins and control logic, for example stopwatch start/stop/lap or clock set-time entry.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/key_encode.sv | 26 ++
 rtl/keypad_scan.sv | 118 +++++++++++
 tb/tb_keypad_scan.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key code map for the 3x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_COLS = 3;
  localparam int KP_ROWS = 4;
  localparam int KP_KEYS = KP_COLS * KP_ROWS;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic {
    IDLE,
    PRESSED
  } kp_state_e;

  // Snapshot bit index (row*3 + col) to key code; indices 0..8 are digits 1..9.
  function automatic logic [3:0] keyCodeOf(input logic [3:0] idx);
    case (idx)
      4'd9:    return KEY_STAR;
      4'd10:   return 4'h0;
      4'd11:   return KEY_HASH;
      default: return idx + 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/key_encode.sv
// Classifies a 12-bit keypad snapshot: flags exactly-one-key-down and encodes that key.
module key_encode
  import keypad_pkg::*;
(
  input  logic [KP_KEYS-1:0] snap_i,
  output logic               single,
  output logic [3:0]         code
);

  logic [3:0] ones;
  logic [3:0] idx;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (snap_i[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end
    single = (ones == 4'd1);
    code   = keyCodeOf(idx);
  end

endmodule

// File: rtl/keypad_scan.sv
// Column-multiplexed keypad scanner: synchronizes rows, debounces whole-frame snapshots
// and reports each debounced single-key press as a one-cycle pulse with its code.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] key_row,
  output logic [KP_COLS-1:0] key_col,
  output logic               key_valid,
  output logic [3:0]         key_code,
  output logic               key_held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [KP_ROWS-1:0] rowMeta_q, rowSync_q;
  logic [SW-1:0]      slotCnt_q;
  logic [KP_COLS-1:0] keyCol_q;
  logic [KP_KEYS-1:0] rawSnap_q, prevSnap_q, stableSnap_q, stableSnap_d;
  logic [DW-1:0]      dbCnt_q, dbCnt_d;
  kp_state_e          state_q;
  logic               keyValid_q, keyHeld_q;
  logic [3:0]         keyCode_q;

  logic               slotEnd, frameEnd, loadStable, single;
  logic [KP_KEYS-1:0] frameSnap;
  logic [3:0]         code;

  // frameSnap already carries this cycle's sample, so frame end compares the completed frame.
  always_comb begin
    slotEnd  = (slotCnt_q == SW'(SCAN_DIV - 1));
    frameEnd = slotEnd && keyCol_q[KP_COLS-1];
    frameSnap = rawSnap_q;
    for (int r = 0; r < KP_ROWS; r++) begin
      for (int c = 0; c < KP_COLS; c++) begin
        if (keyCol_q[c]) frameSnap[r*KP_COLS + c] = rowSync_q[r];
      end
    end
    dbCnt_d = dbCnt_q;
    if (frameEnd) begin
      if (frameSnap == prevSnap_q) begin
        if (dbCnt_q != DW'(DEBOUNCE_FRAMES)) dbCnt_d = dbCnt_q + DW'(1);
      end else begin
        dbCnt_d = '0;
      end
    end
    loadStable   = frameEnd && (dbCnt_d == DW'(DEBOUNCE_FRAMES));
    stableSnap_d = loadStable ? frameSnap : stableSnap_q;
  end

  key_encode u_encode (
    .snap_i (stableSnap_d),
    .single (single),
    .code   (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rowMeta_q    <= '0;
      rowSync_q    <= '0;
      slotCnt_q    <= '0;
      keyCol_q     <= KP_COLS'(1);
      rawSnap_q    <= '0;
      prevSnap_q   <= '0;
      stableSnap_q <= '0;
      dbCnt_q      <= '0;
      state_q      <= IDLE;
      keyValid_q   <= 1'b0;
      keyCode_q    <= 4'h0;
      keyHeld_q    <= 1'b0;
    end else begin
      rowMeta_q    <= key_row;
      rowSync_q    <= rowMeta_q;
      keyValid_q   <= 1'b0;
      dbCnt_q      <= dbCnt_d;
      stableSnap_q <= stableSnap_d;
      if (slotEnd) begin
        slotCnt_q <= '0;
        keyCol_q  <= {keyCol_q[KP_COLS-2:0], keyCol_q[KP_COLS-1]};
        rawSnap_q <= frameSnap;
      end else begin
        slotCnt_q <= slotCnt_q + SW'(1);
      end
      if (frameEnd) prevSnap_q <= frameSnap;
      // A held key must drop back to IDLE before another press can be reported.
      if (loadStable) begin
        case (state_q)
          IDLE: begin
            if (single) begin
              state_q    <= PRESSED;
              keyCode_q  <= code;
              keyValid_q <= 1'b1;
              keyHeld_q  <= 1'b1;
            end
          end
          PRESSED: begin
            if (!single || (code != keyCode_q)) begin
              state_q   <= IDLE;
              keyHeld_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_col   = keyCol_q;
  assign key_valid = keyValid_q;
  assign key_code  = keyCode_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed scenarios plus random key traffic,
// all checked every cycle against a frame-level behavioural model of the keypad scanner.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 12;
  localparam int HIST     = 16384;

  localparam logic [11:0] K1    = 12'h001;
  localparam logic [11:0] K3    = 12'h004;
  localparam logic [11:0] K5    = 12'h010;
  localparam logic [11:0] K9    = 12'h100;
  localparam logic [11:0] KSTAR = 12'h200;
  localparam logic [11:0] K0    = 12'h400;
  localparam logic [11:0] KHASH = 12'h800;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [11:0] keys;

  int testsRun    = 0;
  int testsFailed = 0;
  int absCyc      = 0;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // The keypad itself: a row line is high when a pressed key sits in the driven column.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_col[c] && keys[r*3 + c]) key_row[r] = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, absCyc);
    end
  endtask

  // Frame-level reference: cycle t since reset, key history, whole-frame debounce and press tracking.
  int          t = 0;
  bit          modelOn = 1'b0;
  logic [11:0] hist [HIST];
  logic [11:0] prevSnap;
  int          cnt;
  bit          mHeld;
  int          mIdx;
  logic        expValid;
  logic [3:0]  expCode;
  logic        expHeld;
  logic [2:0]  expCol;
  logic [3:0]  codeMap [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                                 4'hA, 4'h0, 4'hB};
  logic [3:0]  validLog [$];
  int          lastValidCyc = -1;

  task automatic modelFrameEnd();
    logic [11:0] snap;
    int ones;
    int idx;
    snap = '0;
    // Column c is sampled at its slot end, through two synchronizer stages.
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        snap[r*3 + c] = hist[t - 2 - 4*(2 - c)][r*3 + c];
    if (snap == prevSnap) cnt = (cnt < DEB) ? cnt + 1 : DEB;
    else cnt = 0;
    prevSnap = snap;
    if (cnt == DEB) begin
      ones = $countones(snap);
      idx  = -1;
      for (int i = 0; i < 12; i++) if (snap[i]) idx = i;
      if (!mHeld) begin
        if (ones == 1) begin
          expValid = 1'b1;
          expCode  = codeMap[idx];
          mHeld    = 1'b1;
          mIdx     = idx;
        end
      end else if (ones != 1 || idx != mIdx) begin
        mHeld = 1'b0;
      end
    end
    expHeld = mHeld;
  endtask

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("key_col",   key_col,   expCol);
      checkOutput("key_valid", key_valid, expValid);
      checkOutput("key_code",  key_code,  expCode);
      checkOutput("key_held",  key_held,  expHeld);
      if (key_valid === 1'b1) begin
        validLog.push_back(key_code);
        lastValidCyc = absCyc;
      end
    end
    absCyc++;
    if (rst) begin
      modelOn  = 1'b1;
      t        = 0;
      prevSnap = '0;
      cnt      = 0;
      mHeld    = 1'b0;
      mIdx     = -1;
      expValid = 1'b0;
      expCode  = 4'h0;
      expHeld  = 1'b0;
      expCol   = 3'b001;
    end else if (modelOn) begin
      if (t < HIST) hist[t] = keys;
      expValid = 1'b0;
      if (t % 4 == 3 && (t / 4) % 3 == 2 && t < HIST) modelFrameEnd();
      t++;
      expCol = 3'(3'b001 << ((t / 4) % 3));
    end
  end

  task automatic applyStimulus(input logic [11:0] k, input int cycles);
    keys = k;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitPhase(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int v0;
  int s;
  logic [11:0] rk;

  initial begin
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset col",   key_col,   3'b001);
    checkOutput("reset valid", key_valid, 1'b0);
    checkOutput("reset code",  key_code,  4'h0);
    checkOutput("reset held",  key_held,  1'b0);
    applyStimulus('0, 4);
    checkOutput("col step 010", key_col, 3'b010);
    applyStimulus('0, 4);
    checkOutput("col step 100", key_col, 3'b100);
    applyStimulus('0, 4);
    checkOutput("col step 001", key_col, 3'b001);
    applyStimulus('0, 24);
    checkOutput("idle no press", validLog.size(), 0);

    // Clean press of "5", aligned to a frame start.
    waitPhase(0);
    v0 = validLog.size();
    s  = absCyc;
    applyStimulus(K5, 120);
    checkOutput("press5 count",   validLog.size() - v0, 1);
    checkOutput("press5 code",    key_code, 4'h5);
    checkOutput("press5 latency", lastValidCyc - s, 48);
    checkOutput("press5 held",    key_held, 1'b1);
    waitPhase(0);
    applyStimulus('0, 47);
    checkOutput("release5 held before", key_held, 1'b1);
    applyStimulus('0, 1);
    checkOutput("release5 held after",  key_held, 1'b0);
    applyStimulus('0, 24);

    // Bounce on "0" every 7 cycles, then settle pressed.
    waitPhase(5);
    v0 = validLog.size();
    s  = absCyc;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? K0 : 12'h000, 7);
    checkOutput("bounce no valid", validLog.size() - v0, 0);
    applyStimulus(K0, 60);
    checkOutput("bounce count",   validLog.size() - v0, 1);
    checkOutput("bounce code",    key_code, 4'h0);
    checkOutput("bounce latency", lastValidCyc - s, 91);
    applyStimulus('0, 72);

    // Rollover: "1", then "1"+"#", then "#" alone.
    waitPhase(0);
    v0 = validLog.size();
    applyStimulus(K1, 60);
    applyStimulus(K1 | KHASH, 60);
    checkOutput("rollover held drop", key_held, 1'b0);
    applyStimulus(KHASH, 72);
    checkOutput("rollover count", validLog.size() - v0, 2);
    if (validLog.size() >= v0 + 2) begin
      checkOutput("rollover first",  validLog[v0],     4'h1);
      checkOutput("rollover second", validLog[v0 + 1], 4'hB);
    end
    applyStimulus('0, 72);

    // Two keys down together never count as a press.
    v0 = validLog.size();
    applyStimulus(KSTAR | K9, 120);
    checkOutput("multi no valid", validLog.size() - v0, 0);
    checkOutput("multi held",     key_held, 1'b0);
    checkOutput("multi code",     key_code, 4'hB);
    applyStimulus('0, 72);

    // Reset while "3" is held: fresh press once debounced again.
    applyStimulus(K3, 72);
    checkOutput("pre-reset held", key_held, 1'b1);
    checkOutput("pre-reset code", key_code, 4'h3);
    pulseReset();
    checkOutput("midreset col",   key_col,   3'b001);
    checkOutput("midreset valid", key_valid, 1'b0);
    checkOutput("midreset code",  key_code,  4'h0);
    checkOutput("midreset held",  key_held,  1'b0);
    v0 = validLog.size();
    s  = absCyc;
    applyStimulus(K3, 72);
    checkOutput("postreset count",   validLog.size() - v0, 1);
    checkOutput("postreset code",    key_code, 4'h3);
    checkOutput("postreset latency", lastValidCyc - s, 48);
    applyStimulus('0, 72);

    // Random traffic: none, single or double keys for random spans, with rare resets.
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0:       rk = '0;
        1, 2:    rk = 12'(1) << $urandom_range(0, 11);
        default: rk = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      endcase
      if ($urandom_range(0, 24) == 0) begin
        keys = rk;
        pulseReset();
      end
      applyStimulus(rk, $urandom_range(1, 70));
    end
    applyStimulus('0, 72);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
